uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the multicycle RISC-V data bus, downstream of the processor and in parallel with the unified memory. It snoops the processor's `MemWrite`/`DataAdr`/`WriteData` outputs, queues bytes written to a TX data address in a small FIFO, and serializes them as 8N1 frames on `tx`. It also returns a status word that the top level muxes into `ReadData` when `StatusSel` is high.

---
 rtl/uart_tx_mmio_if.sv | 12 +
 rtl/uart_tx_mmio.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// Processor data-bus snoop port for the UART: store strobe, address and data in,
// plus the status word and its read-select back towards the ReadData mux.
interface uart_tx_mmio_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] StatusData;
  logic        StatusSel;

  modport master (output MemWrite, DataAdr, WriteData, input StatusData, StatusSel);
  modport slave  (input MemWrite, DataAdr, WriteData, output StatusData, StatusSel);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR fill a small FIFO that the
// serializer drains LSB first; STAT_ADDR exposes fill level, busy and sticky overflow.
module uart_tx_mmio #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0104,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            wr_tx, wr_stat;
  logic            full, empty;
  logic            push, pop;
  logic            baud_last;
  logic [3:0]      cnt_stat;
  logic            unused_wdata;

  // ---------------------------------------------------------------------------
  // Bus decode and FIFO flags
  // ---------------------------------------------------------------------------
  assign wr_tx     = bus.MemWrite && (bus.DataAdr == TX_ADDR);
  assign wr_stat   = bus.MemWrite && (bus.DataAdr == STAT_ADDR);
  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // does not make room for the incoming byte.
  assign push      = wr_tx && !full;
  assign pop       = (state_q == IDLE) && !empty;
  assign baud_last = (baud_q == BAUD_LAST);

  assign unused_wdata = ^bus.WriteData[31:8];

  // ---------------------------------------------------------------------------
  // FIFO pointers, count and sticky overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first so that a simultaneous drop-on-full keeps the flag set.
    if (wr_stat && bus.WriteData[2]) ovf_d = 1'b0;
    if (wr_tx && full)               ovf_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Serializer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // Next bit goes out on the same edge as the shift.
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wptr_q] <= bus.WriteData[7:0];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cnt_stat       = 4'(cnt_q);
  assign tx             = tx_q;
  assign busy           = (state_q != IDLE) || !empty;
  assign bus.StatusSel  = (bus.DataAdr == STAT_ADDR);
  assign bus.StatusData = {24'h0, cnt_stat, empty, ovf_q, busy, full};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio (C=4, depth 4): a queue/frame-time model is
// compared every cycle, and literal expectations pin key timing points.
module tb_uart_tx_mmio;
  localparam int C = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .TX_ADDR(32'h0000_0100), .STAT_ADDR(32'h0000_0104),
    .CLKS_PER_BIT(C), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int last_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: byte queue plus "cycles since the pop edge" of the frame in flight.
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_full_b, m_empty_b, m_wr_tx, m_wr_stat;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
      m_ovf = 1'b0;
    end else begin
      m_wr_tx   = bus.MemWrite && (bus.DataAdr == 32'h100);
      m_wr_stat = bus.MemWrite && (bus.DataAdr == 32'h104);
      m_full_b  = (mq.size() == D);
      m_empty_b = (mq.size() == 0);
      if (m_act) begin
        m_t++;
        if (m_t == 10 * C) m_act = 1'b0;
      end else if (!m_empty_b) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_t   = 0;
      end
      if (m_wr_stat && bus.WriteData[2]) m_ovf = 1'b0;
      if (m_wr_tx) begin
        if (m_full_b) m_ovf = 1'b1;
        else          mq.push_back(bus.WriteData[7:0]);
      end
    end
  end

  function automatic logic exp_tx();
    if (!m_act)       return 1'b1;
    if (m_t < C)      return 1'b0;
    if (m_t < 9 * C)  return m_cur[(m_t - C) / C];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return m_act || (mq.size() != 0);
  endfunction

  function automatic logic [31:0] exp_stat();
    int n;
    n = mq.size();
    return {24'h0, 4'(n), (n == 0), m_ovf, exp_busy(), (n == D)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (cyc >= 1) begin
      chk("m_tx",     32'(tx),             32'(exp_tx()));
      chk("m_busy",   32'(busy),           32'(exp_busy()));
      chk("m_status", bus.StatusData,      exp_stat());
      chk("m_sel",    32'(bus.StatusSel),  32'(bus.DataAdr == 32'h104));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = a;
    bus.WriteData = d;
    @(negedge clk);
    last_wr       = cyc;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h0;
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic read_stat();
    bus.DataAdr = 32'h104;
    #1;
  endtask

  int lows;
  int k;
  int w;
  logic bits55 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_stat();
    chk("rst_status", bus.StatusData, 32'h0000_0008);
    chk("rst_tx",     32'(tx),        32'h1);
    chk("rst_busy",   32'(busy),      32'h0);

    // Single frame 0x55, upper data bits ignored
    wr(32'h100, 32'hFFFF_FF55);
    #1;
    chk("t1_queued_status", bus.StatusData, 32'h0000_0012);
    step(1);
    chk("t1_start", 32'(tx), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(C);
      chk($sformatf("t1_bit%0d", i), 32'(tx), 32'(bits55[i]));
    end
    step(C);
    chk("t1_stop_tx",   32'(tx),   32'h1);
    chk("t1_stop_busy", 32'(busy), 32'h1);
    step(3);
    chk("t1_busy_n40", 32'(busy), 32'h1);
    step(1);
    chk("t1_busy_n41", 32'(busy), 32'h0);

    // Back-to-back frames 0x41/0x42/0x43
    @(negedge clk); bus.MemWrite = 1'b1; bus.DataAdr = 32'h100; bus.WriteData = 32'h41;
    @(negedge clk); bus.WriteData = 32'h42;
    @(negedge clk); bus.WriteData = 32'h43;
    @(negedge clk); bus.MemWrite = 1'b0; bus.WriteData = 32'h0;
    read_stat();
    chk("t2_count2",  bus.StatusData,          32'h0000_0022);
    chk("t2_sel_104", 32'(bus.StatusSel),      32'h1);
    step(39);
    chk("t2_gap_tx",   32'(tx),   32'h1);
    chk("t2_gap_busy", 32'(busy), 32'h1);
    step(1);
    chk("t2_start2", 32'(tx), 32'h0);
    step(40);
    chk("t2_gap2_tx", 32'(tx), 32'h1);
    step(1);
    chk("t2_start3", 32'(tx), 32'h0);
    k = 0;
    while (busy && k < 200) begin step(1); k++; end
    chk("t2_drained", 32'(busy), 32'h0);

    // Overflow while transmitting
    wr(32'h100, 32'hA0);
    w = last_wr;
    wr(32'h100, 32'hB1);
    wr(32'h100, 32'hB2);
    wr(32'h100, 32'hB3);
    wr(32'h100, 32'hB4);
    wr(32'h100, 32'hB5);
    read_stat();
    chk("t3_full_ovf", bus.StatusData, 32'h0000_0047);
    wr(32'h104, 32'h0000_0003);
    read_stat();
    chk("t3_noclear", bus.StatusData, 32'h0000_0047);
    wr(32'h104, 32'h0000_0004);
    read_stat();
    chk("t3_cleared", bus.StatusData, 32'h0000_0043);

    // Push to full FIFO on the same edge as the IDLE pop
    wait_until(w + 41);
    bus.MemWrite = 1'b1; bus.DataAdr = 32'h100; bus.WriteData = 32'hC5;
    @(negedge clk); bus.MemWrite = 1'b0; bus.WriteData = 32'h0;
    read_stat();
    chk("t4_pop_drop", bus.StatusData, 32'h0000_0036);
    chk("t4_start",    32'(tx),        32'h0);

    // Reset mid-DATA with a write on the reset edge
    wait_until(w + 50);
    reset = 1'b1; bus.MemWrite = 1'b1; bus.DataAdr = 32'h100; bus.WriteData = 32'h77;
    @(negedge clk);
    reset = 1'b0; bus.MemWrite = 1'b0; bus.WriteData = 32'h0;
    read_stat();
    chk("t5_tx",     32'(tx),             32'h1);
    chk("t5_status", bus.StatusData,      32'h0000_0008);
    chk("t5_sel",    32'(bus.StatusSel),  32'h1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    chk("t5_no_frame", 32'(lows), 32'h0);

    // Address decode
    bus.DataAdr = 32'h100; #1;
    chk("t6_sel_100", 32'(bus.StatusSel), 32'h0);
    bus.DataAdr = 32'h0; #1;
    chk("t6_sel_0",   32'(bus.StatusSel), 32'h0);
    wr(32'h108, 32'h99);
    read_stat();
    chk("t6_other_addr", bus.StatusData, 32'h0000_0008);
    wr(32'h000, 32'h5A);
    read_stat();
    chk("t6_addr0",      bus.StatusData, 32'h0000_0008);
    chk("t6_idle_busy",  32'(busy),      32'h0);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
